hbridge_pwm_gen: RTL and testbench



---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_deadtime.sv | 86 ++++++++
 rtl/hbridge_pwm_gen.sv | 110 +++++++++++
 tb/tb_hbridge_pwm_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, FSM state encoding and duty helpers for the H-bridge PWM generator.
package pwm_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DEAD_W = 6;

    typedef enum logic [1:0] {
        OFF_BOTH = 2'b00,
        HI_ON    = 2'b01,
        DEAD     = 2'b10,
        LO_ON    = 2'b11
    } pwm_state_e;

    // Saturate a duty word at a ceiling.
    function automatic logic [CNT_W-1:0] duty_clamp(input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W-1:0] dmax);
        return (d > dmax) ? dmax : d;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time FSM for one complementary leg: never drives both switches, and
// always passes through DEAD before a switch turns on.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic en,
    input  logic force_off,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam logic [DEAD_W-1:0] DEAD_LD = DEAD_W'(DEAD_CYCLES);
    localparam bit                NO_DEAD = (DEAD_CYCLES == 0);

    pwm_state_e        state;
    logic [DEAD_W-1:0] dead_cnt;

    // State, dead counter and gate enables; outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF_BOTH;
            dead_cnt <= '0;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
        end else if (force_off || !en) begin
            state    <= OFF_BOTH;
            dead_cnt <= '0;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
        end else begin
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
            case (state)
                OFF_BOTH: begin
                    if (NO_DEAD) begin
                        state  <= raw ? HI_ON : LO_ON;
                        pwm_hi <= raw;
                        pwm_lo <= !raw;
                    end else begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_LD;
                    end
                end
                HI_ON: begin
                    if (raw) begin
                        pwm_hi <= 1'b1;
                    end else if (NO_DEAD) begin
                        state  <= LO_ON;
                        pwm_lo <= 1'b1;
                    end else begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_LD;
                    end
                end
                LO_ON: begin
                    if (!raw) begin
                        pwm_lo <= 1'b1;
                    end else if (NO_DEAD) begin
                        state  <= HI_ON;
                        pwm_hi <= 1'b1;
                    end else begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_LD;
                    end
                end
                DEAD: begin
                    // Only the demand seen at expiry decides which side turns on.
                    if (dead_cnt <= DEAD_W'(1)) begin
                        state  <= raw ? HI_ON : LO_ON;
                        pwm_hi <= raw;
                        pwm_lo <= !raw;
                    end else begin
                        dead_cnt <= dead_cnt - DEAD_W'(1);
                    end
                end
                default: state <= OFF_BOTH;
            endcase
        end
    end

endmodule

// File: rtl/hbridge_pwm_gen.sv
// Carrier-based PWM generator for one H-bridge leg with shadowed duty,
// dead-time insertion and a latched fault shutdown.
// Optional build macro PWM_DUTY_CLAMP_EN: captured duty saturates at DUTY_MAX.
module hbridge_pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned      PRESC_DIV   = 2,
    parameter int unsigned      DEAD_CYCLES = 4,
    parameter logic [CNT_W-1:0] DUTY_MAX    = 8'd242
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic             duty_valid,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic             fault_active
);

    localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   pending_duty;
    logic [CNT_W-1:0]   active_duty;
    logic [CNT_W-1:0]   duty_cap_c;
    logic               tick_c;
    logic               wrap_c;
    logic               raw_c;
    logic               force_off_c;

    assign tick_c      = (presc == PRESC_W'(PRESC_DIV - 1));
    assign wrap_c      = tick_c && (cnt == '1);
    assign raw_c       = (cnt < active_duty);
    assign force_off_c = fault || fault_active;

`ifdef PWM_DUTY_CLAMP_EN
    assign duty_cap_c = duty_clamp(duty, DUTY_MAX);
`else
    assign duty_cap_c = duty;
    logic unused_duty_max;
    assign unused_duty_max = ^DUTY_MAX;
`endif

    // Prescaler and carrier; both parked at zero while the bridge is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            cnt   <= '0;
        end else if (!en) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick_c ? '0 : presc + PRESC_W'(1);
            if (tick_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Wrap marker and shadow-to-active duty transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            active_duty  <= '0;
        end else begin
            period_start <= en && wrap_c;
            if (en && wrap_c) begin
                active_duty <= pending_duty;
            end
        end
    end

    // Duty capture into the shadow register; runs regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_duty <= '0;
        end else if (duty_valid) begin
            pending_duty <= duty_cap_c;
        end
    end

    // Fault latch; a live fault beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_active <= 1'b0;
        end else if (fault) begin
            fault_active <= 1'b1;
        end else if (fault_clr) begin
            fault_active <= 1'b0;
        end
    end

    pwm_deadtime #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_deadtime (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (raw_c),
        .en        (en),
        .force_off (force_off_c),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo)
    );

endmodule

// File: tb/tb_hbridge_pwm_gen.sv
// Self-checking bench for hbridge_pwm_gen (default parameters).
module tb_hbridge_pwm_gen;

    localparam int PRESC  = 2;
    localparam int DEAD_T = 4;
    localparam int PERIOD = 256 * PRESC;
`ifdef PWM_DUTY_CLAMP_EN
    localparam int DMAX = 242;
`else
    localparam int DMAX = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] duty = 8'd0;
    logic       duty_valid = 1'b0;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       pwm_hi, pwm_lo, period_start, fault_active;

    int n_total = 0;
    int n_pass  = 0;

    hbridge_pwm_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .fault_active (fault_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] duty;
        int         hi;
        int         lo;
        int         gap;
    } vec_t;

    vec_t vecs[9];

    // Reference model state: elapsed carrier clocks, shadow duties, fault latch,
    // conducting side (0 none, 1 high, 2 low, 3 blanking) and blanking length so far.
    int         m_k;
    int         m_side;
    int         m_gap;
    logic [7:0] m_pend;
    logic [7:0] m_act;
    bit         m_fa;
    bit         m_ps;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 16; i++) begin
            cyc(1);
            if (period_start) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_hi(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 16; i++) begin
            cyc(1);
            if (pwm_hi) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic load_duty(input logic [7:0] d);
        bit ok;
        duty = d;
        duty_valid = 1'b1;
        cyc(1);
        duty_valid = 1'b0;
        wait_ps(ok);
        check("settle wrap 1", int'(ok), 1);
        wait_ps(ok);
        check("settle wrap 2", int'(ok), 1);
    endtask

    // One carrier period of observation, optionally strobing a new duty at offset drive_at.
    task automatic period_win(input int drive_at, input logic [7:0] dval,
                              output int hi, output int lo, output int gap,
                              output int ps, output int both);
        hi = 0; lo = 0; gap = 0; ps = 0; both = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_hi) hi++;
            if (pwm_lo) lo++;
            if (!pwm_hi && !pwm_lo) gap++;
            if (pwm_hi && pwm_lo) both++;
            if (period_start) ps++;
            if (i == drive_at) begin
                duty = dval;
                duty_valid = 1'b1;
            end else begin
                duty_valid = 1'b0;
            end
            cyc(1);
        end
        duty_valid = 1'b0;
    endtask

    // Advance the reference model across one clock edge using the current inputs.
    task automatic model_step();
        int  cnt_now;
        bit  raw;
        bit  wrap;
        bit  go;
        int  dv;
        cnt_now = (m_k / PRESC) % 256;
        raw     = (cnt_now < int'(m_act));
        wrap    = en && ((m_k % PERIOD) == PERIOD - 1);
        go      = 1'b0;
        if (fault || m_fa || !en) begin
            m_side = 0;
        end else begin
            case (m_side)
                0: go = 1'b1;
                1: go = !raw;
                2: go = raw;
                default: begin
                    m_gap++;
                    if (m_gap >= DEAD_T) m_side = raw ? 1 : 2;
                end
            endcase
            if (go) begin
                if (DEAD_T == 0) m_side = raw ? 1 : 2;
                else begin
                    m_side = 3;
                    m_gap  = 0;
                end
            end
        end
        m_ps = wrap;
        if (wrap) m_act = m_pend;
        if (duty_valid) begin
            dv = int'(duty);
            if (dv > DMAX) dv = DMAX;
            m_pend = 8'(dv);
        end
        if (fault) m_fa = 1'b1;
        else if (fault_clr) m_fa = 1'b0;
        m_k = en ? m_k + 1 : 0;
    endtask

    initial begin
        bit ok;
        int hi, lo, gap, ps, both, on_cnt, n, first_on, first_hi, ps_at, rfail;
        bit vmode;

        vecs[0] = '{8'd128, 252, 252, 8};
        vecs[1] = '{8'd0,   0,   512, 0};
        vecs[2] = '{8'd1,   0,   508, 4};
        vecs[3] = '{8'd2,   0,   508, 4};
        vecs[4] = '{8'd3,   2,   502, 8};
        vecs[5] = '{8'd64,  124, 380, 8};
        vecs[6] = '{8'd192, 380, 124, 8};
`ifdef PWM_DUTY_CLAMP_EN
        vecs[7] = '{8'd255, 480, 24,  8};
        vecs[8] = '{8'd250, 480, 24,  8};
`else
        vecs[7] = '{8'd255, 508, 0,   4};
        vecs[8] = '{8'd250, 496, 8,   8};
`endif

        // Reset state
        #22;
        check("reset pwm_hi", int'(pwm_hi), 0);
        check("reset pwm_lo", int'(pwm_lo), 0);
        check("reset period_start", int'(period_start), 0);
        check("reset fault_active", int'(fault_active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        cyc(1);

        // Steady-state pulse widths per duty
        for (int v = 0; v < 9; v++) begin
            load_duty(vecs[v].duty);
            period_win(-1, 8'd0, hi, lo, gap, ps, both);
            check($sformatf("duty %0d hi width", vecs[v].duty), hi, vecs[v].hi);
            check($sformatf("duty %0d lo width", vecs[v].duty), lo, vecs[v].lo);
            check($sformatf("duty %0d gap", vecs[v].duty), gap, vecs[v].gap);
            check($sformatf("duty %0d period_start count", vecs[v].duty), ps, 1);
            check($sformatf("duty %0d overlap", vecs[v].duty), both, 0);
        end

        // Fault latch, hold, clear and restart through dead time
        load_duty(8'd128);
        wait_hi(ok);
        check("fault wait pwm_hi", int'(ok), 1);
        fault = 1'b1;
        cyc(1);
        fault = 1'b0;
        check("fault pwm_hi off", int'(pwm_hi), 0);
        check("fault pwm_lo off", int'(pwm_lo), 0);
        check("fault latched", int'(fault_active), 1);
        on_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < PERIOD + 8 && !ok; i++) begin
            cyc(1);
            if (pwm_hi || pwm_lo) on_cnt++;
            if (period_start) ok = 1'b1;
        end
        check("faulted carrier period_start", int'(ok), 1);
        check("faulted outputs off", on_cnt, 0);
        fault = 1'b1;
        fault_clr = 1'b1;
        cyc(1);
        fault = 1'b0;
        fault_clr = 1'b0;
        check("fault beats fault_clr", int'(fault_active), 1);
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        check("fault_clr clears", int'(fault_active), 0);
        n = 0;
        while (!(pwm_hi || pwm_lo) && n < 20) begin
            cyc(1);
            n++;
        end
        check("post-clear edges to output", n, DEAD_T + 1);

        // Enable drop and restart
        wait_hi(ok);
        check("enable wait pwm_hi", int'(ok), 1);
        en = 1'b0;
        cyc(1);
        check("disable outputs off", int'(pwm_hi || pwm_lo), 0);
        on_cnt = 0;
        ps = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (pwm_hi || pwm_lo) on_cnt++;
            if (period_start) ps++;
        end
        check("disabled outputs stay off", on_cnt, 0);
        check("disabled carrier halted", ps, 0);
        en = 1'b1;
        first_on = -1;
        first_hi = 0;
        ps_at = -1;
        for (int e = 1; e <= PERIOD + 20 && (first_on < 0 || ps_at < 0); e++) begin
            cyc(1);
            if (first_on < 0 && (pwm_hi || pwm_lo)) begin
                first_on = e;
                first_hi = int'(pwm_hi);
            end
            if (ps_at < 0 && period_start) ps_at = e;
        end
        check("restart edges to output", first_on, DEAD_T + 1);
        check("restart first side high", first_hi, 1);
        check("restart carrier from zero", ps_at, PERIOD);

        // Mid-period and wrap-coincident duty updates
        load_duty(8'd64);
        period_win(40, 8'd192, hi, lo, gap, ps, both);
        check("mid-period change old duty holds", hi, 124);
        check("mid-period overlap", both, 0);
        check("wrap after window 1", int'(period_start), 1);
        period_win(0, 8'd64, hi, lo, gap, ps, both);
        check("new duty after wrap", hi, 380);
        check("wrap after window 2", int'(period_start), 1);
        period_win(PERIOD - 1, 8'd192, hi, lo, gap, ps, both);
        check("period_start-coincident capture applies", hi, 124);
        check("wrap after window 3", int'(period_start), 1);
        period_win(-1, 8'd0, hi, lo, gap, ps, both);
        check("wrap-edge capture deferred", hi, 124);
        check("wrap-edge overlap", both, 0);
        period_win(-1, 8'd0, hi, lo, gap, ps, both);
        check("wrap-edge capture applies next", hi, 380);

        // Asynchronous reset mid-pulse
        load_duty(8'd200);
        wait_hi(ok);
        check("reset wait pwm_hi", int'(ok), 1);
        #3;
        rst_n = 1'b0;
        en = 1'b0;
        fault = 1'b0;
        fault_clr = 1'b0;
        duty_valid = 1'b0;
        #1;
        check("async reset pwm_hi", int'(pwm_hi), 0);
        check("async reset pwm_lo", int'(pwm_lo), 0);
        check("async reset period_start", int'(period_start), 0);
        check("async reset fault_active", int'(fault_active), 0);

        // Randomized run against the reference model
        m_k = 0; m_side = 0; m_gap = 0;
        m_pend = 8'd0; m_act = 8'd0; m_fa = 1'b0; m_ps = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        rfail = 0;
        for (int i = 0; i < 6000 && rfail < 20; i++) begin
            vmode = ((i / 1500) % 2) == 1;
            duty = 8'($urandom);
            duty_valid = vmode ? 1'b1 : ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 2) en = ~en;
            fault = ($urandom_range(0, 999) < 2);
            fault_clr = ($urandom_range(0, 99) < 2);
            model_step();
            cyc(1);
            n = n_total - n_pass;
            check($sformatf("random cycle %0d {hi,lo,ps,fa}", i),
                  int'({pwm_hi, pwm_lo, period_start, fault_active}),
                  int'({m_side == 1, m_side == 2, m_ps, m_fa}));
            if (n_total - n_pass != n) rfail++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
